// File: rtl/uart_tx_arbiter_pkg.sv
// Shared constants and state encoding for the UART transmit-FIFO arbiter.
package uart_tx_arbiter_pkg;

    localparam int UART_FIFO_DEPTH     = 16;
    localparam int UART_FIFO_COUNTER_W = 5;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1
    } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin first-valid search: lowest offset from ptr (mod NREQ) with valid set wins.
module uart_tx_arbiter_rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IW-1:0]   ptr,
    output logic            found,
    output logic [IW-1:0]   idx
);

    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= NREQ) s = s - NREQ;
        return IW'(s);
    endfunction

    // Scan from the far end down so the nearest offset is written last and wins.
    always_comb begin
        found = |valid;
        idx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (valid[wrap_add(ptr, i)]) idx = wrap_add(ptr, i);
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART TX FIFO among NREQ byte-stream requesters, round-robin with burst limit.
// state   | meaning
// S_IDLE  | no grant; pick next requester from rr_ptr
// S_GRANT | grant_id owns the FIFO until req_last, MAX_BURST bytes, or tx_reset
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter  int NREQ       = 4,
    parameter  int MAX_BURST  = 8,
    parameter  int FIFO_DEPTH = UART_FIFO_DEPTH,
    localparam int IW         = $clog2(NREQ)
) (
    input  logic                           clk,
    input  logic                           wb_rst_ni,
    input  logic [NREQ-1:0]                req_valid,
    input  logic [8*NREQ-1:0]              req_data,
    input  logic [NREQ-1:0]                req_last,
    output logic [NREQ-1:0]                req_ready,
    input  logic [UART_FIFO_COUNTER_W-1:0] tf_count,
    input  logic [2:0]                     tstate,
    input  logic                           tx_reset,
    output logic                           tf_push,
    output logic [7:0]                     tf_data,
    output logic [IW-1:0]                  grant_id,
    output logic                           busy,
    output logic                           tx_idle
);

    localparam int CW = UART_FIFO_COUNTER_W;
    localparam int BW = 5;

    arb_state_e     state_q, state_d;
    logic [IW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]  grant_d;
    logic [BW-1:0]  burst_q, burst_d;
    logic           push_d, busy_d, idle_d;
    logic [7:0]     data_d;

    logic           space_ok, xfer, pick_found;
    logic [IW-1:0]  pick_idx, grant_nxt;
    logic [7:0]     g_byte;
    logic           g_last, g_valid;

    uart_tx_arbiter_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .valid (req_valid),
        .ptr   (rr_ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // The registered push has not reached tf_count yet, so it is counted here.
    assign space_ok  = ({1'b0, tf_count} + (CW+1)'(tf_push)) < (CW+1)'(FIFO_DEPTH);
    assign g_byte    = req_data[8*grant_id +: 8];
    assign g_last    = req_last[grant_id];
    assign g_valid   = req_valid[grant_id];
    assign grant_nxt = (grant_id == IW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
    assign xfer      = (state_q == S_GRANT) && g_valid && space_ok && !tx_reset;

    always_comb begin
        req_ready = '0;
        if (state_q == S_GRANT && space_ok && !tx_reset) req_ready[grant_id] = 1'b1;
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_id;
        burst_d  = burst_q;
        push_d   = 1'b0;
        data_d   = tf_data;
        busy_d   = busy;
        idle_d   = (tf_count == '0) && !tf_push && (tstate == 3'd0) && !busy;
        if (tx_reset) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pick_found) begin
                        grant_d = pick_idx;
                        busy_d  = 1'b1;
                        burst_d = '0;
                        state_d = S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (xfer) begin
                        push_d  = 1'b1;
                        data_d  = g_byte;
                        burst_d = burst_q + 1'b1;
                        if (g_last || burst_q == BW'(MAX_BURST - 1)) begin
                            rr_ptr_d = grant_nxt;
                            busy_d   = 1'b0;
                            state_d  = S_IDLE;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q  <= S_IDLE;
            tf_push  <= 1'b0;
            tf_data  <= 8'h00;
            grant_id <= '0;
            busy     <= 1'b0;
            rr_ptr_q <= '0;
            burst_q  <= '0;
            tx_idle  <= 1'b1;
        end else begin
            state_q  <= state_d;
            tf_push  <= push_d;
            tf_data  <= data_d;
            grant_id <= grant_d;
            busy     <= busy_d;
            rr_ptr_q <= rr_ptr_d;
            burst_q  <= burst_d;
            tx_idle  <= idle_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a behavioural TX FIFO occupancy model.
module tb_uart_tx_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic [4:0]  tf_count;
    logic [2:0]  tstate;
    logic        tx_reset;
    logic        tf_push;
    logic [7:0]  tf_data;
    logic [1:0]  grant_id;
    logic        busy;
    logic        tx_idle;

    uart_tx_arbiter #(.NREQ(4), .MAX_BURST(8), .FIFO_DEPTH(16)) dut (
        .clk       (clk),
        .wb_rst_ni (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tf_count  (tf_count),
        .tstate    (tstate),
        .tx_reset  (tx_reset),
        .tf_push   (tf_push),
        .tf_data   (tf_data),
        .grant_id  (grant_id),
        .busy      (busy),
        .tx_idle   (tx_idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [8:0] rq [4][$];
    logic [7:0] exp_q [$];
    int         grant_log [$];
    int         push_cyc [$];
    int         fifo_cnt;
    bit         drain;
    bit         overrun;
    bit         busy_prev;
    int         cyc;
    int         n_push;
    int         vectors;
    int         miscompares;

    task automatic drive_inputs();
        logic [8:0] h;
        for (int i = 0; i < 4; i++) begin
            if (rq[i].size() > 0) begin
                h = rq[i][0];
                req_valid[i]      = 1'b1;
                req_data[8*i +: 8] = h[7:0];
                req_last[i]       = h[8];
            end else begin
                req_valid[i]      = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]       = 1'b0;
            end
        end
        tf_count = 5'(fifo_cnt);
        #1;
    endtask

    // One clock: check outputs at the sample point, advance the edge, update models, drive.
    task automatic step();
        logic [3:0] acc;
        logic [7:0] e;
        bit         push_now, pop_now;
        acc = req_valid & req_ready;
        if (req_ready != 4'b0) begin
            vectors++;
            if (!$onehot(req_ready) || (fifo_cnt + int'(tf_push)) >= 16 || tx_reset) begin
                miscompares++;
                $display("FAIL ready_legal: ready=%b cnt=%0d push=%0d tx_reset=%0d", req_ready, fifo_cnt, tf_push, tx_reset);
            end
        end
        push_now = tf_push;
        if (tf_push) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL push_data: got unexpected byte %h, required none", tf_data);
            end else begin
                e = exp_q.pop_front();
                if (tf_data !== e) begin
                    miscompares++;
                    $display("FAIL push_data: got %h required %h", tf_data, e);
                end
            end
            push_cyc.push_back(cyc);
            n_push++;
            if (fifo_cnt >= 16) overrun = 1'b1;
        end
        if (busy && !busy_prev) grant_log.push_back(int'(grant_id));
        busy_prev = busy;
        pop_now = drain && fifo_cnt > 0;
        @(posedge clk);
        if (tx_reset) fifo_cnt = 0;
        else fifo_cnt = fifo_cnt + int'(push_now) - int'(pop_now);
        for (int i = 0; i < 4; i++) if (acc[i]) void'(rq[i].pop_front());
        cyc++;
        @(negedge clk);
        drive_inputs();
    endtask

    task automatic wait_drain(input int max, input string name);
        int n;
        n = 0;
        while ((exp_q.size() > 0 || rq[0].size() > 0 || rq[1].size() > 0 ||
                rq[2].size() > 0 || rq[3].size() > 0) && n < max) begin
            step();
            n++;
        end
        vectors++;
        if (n >= max) begin
            miscompares++;
            $display("FAIL %s_timeout: %0d bytes still expected after %0d cycles, required 0", name, exp_q.size(), n);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) rq[i].delete();
        exp_q.delete();
        fifo_cnt  = 0;
        tx_reset  = 1'b0;
        tstate    = 3'd0;
        busy_prev = 1'b0;
        drive_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive_inputs();
    endtask

    task automatic check_reset_outputs(input string name);
        vectors++;
        if (tf_push !== 1'b0 || tf_data !== 8'h00 || grant_id !== 2'd0 || busy !== 1'b0 ||
            tx_idle !== 1'b1 || req_ready !== 4'b0) begin
            miscompares++;
            $display("FAIL %s: push=%b data=%h gid=%0d busy=%b idle=%b ready=%b, required 0 00 0 0 1 0000",
                     name, tf_push, tf_data, grant_id, busy, tx_idle, req_ready);
        end
    endtask

    task automatic test_reset();
        do_reset();
        check_reset_outputs("reset_values");
    endtask

    task automatic test_two_msgs();
        drain = 1'b1;
        grant_log.delete();
        push_cyc.delete();
        rq[0] = '{9'h0A1, 9'h0A2, 9'h1A3};
        rq[2] = '{9'h0C1, 9'h0C2, 9'h1C3};
        exp_q = '{8'hA1, 8'hA2, 8'hA3, 8'hC1, 8'hC2, 8'hC3};
        drive_inputs();
        wait_drain(60, "two_msgs");
        vectors++;
        if (grant_log.size() != 2 || grant_log[0] != 0 || grant_log[1] != 2) begin
            miscompares++;
            $display("FAIL two_msgs_grants: got %0d grants first=%0d, required 2 grants 0 then 2",
                     grant_log.size(), grant_log.size() > 0 ? grant_log[0] : -1);
        end
        vectors++;
        if (push_cyc.size() != 6 || push_cyc[1] - push_cyc[0] != 1 || push_cyc[3] - push_cyc[2] != 2) begin
            miscompares++;
            $display("FAIL two_msgs_timing: pushes=%0d, required back-to-back within a message and one idle cycle between",
                     push_cyc.size());
        end
        vectors++;
        if (grant_id !== 2'd2 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL grant_hold_idle: gid=%0d busy=%b, required 2 0", grant_id, busy);
        end
    endtask

    task automatic test_reset_mid_burst();
        for (int k = 0; k < 12; k++) begin
            rq[3].push_back({(k == 11), 8'(8'hE0 + k)});
            exp_q.push_back(8'(8'hE0 + k));
        end
        drive_inputs();
        repeat (5) step();
        vectors++;
        if (busy !== 1'b1 || grant_id !== 2'd3 || tf_push !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset_busy: busy=%b gid=%0d push=%b, required 1 3 1", busy, grant_id, tf_push);
        end
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_mid_burst");
        for (int i = 0; i < 4; i++) rq[i].delete();
        exp_q.delete();
        fifo_cnt  = 0;
        busy_prev = 1'b0;
        drive_inputs();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive_inputs();
    endtask

    task automatic test_burst_rotation();
        int exp_g [5] = '{1, 3, 1, 3, 1};
        drain = 1'b1;
        grant_log.delete();
        for (int k = 0; k < 20; k++) rq[1].push_back({1'b0, 8'(8'h10 + k)});
        for (int k = 0; k < 16; k++) rq[3].push_back({(k == 15), 8'(8'h30 + k)});
        for (int k = 0;  k < 8;  k++) exp_q.push_back(8'(8'h10 + k));
        for (int k = 0;  k < 8;  k++) exp_q.push_back(8'(8'h30 + k));
        for (int k = 8;  k < 16; k++) exp_q.push_back(8'(8'h10 + k));
        for (int k = 8;  k < 16; k++) exp_q.push_back(8'(8'h30 + k));
        for (int k = 16; k < 20; k++) exp_q.push_back(8'(8'h10 + k));
        drive_inputs();
        wait_drain(200, "burst");
        repeat (6) step();
        vectors++;
        if (grant_log.size() != 5) begin
            miscompares++;
            $display("FAIL burst_grant_count: got %0d required 5", grant_log.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                vectors++;
                if (grant_log[i] != exp_g[i]) begin
                    miscompares++;
                    $display("FAIL burst_grant_%0d: got %0d required %0d", i, grant_log[i], exp_g[i]);
                end
            end
        end
        vectors++;
        if (busy !== 1'b1 || grant_id !== 2'd1 || tx_idle !== 1'b0) begin
            miscompares++;
            $display("FAIL held_grant: busy=%b gid=%0d idle=%b, required 1 1 0", busy, grant_id, tx_idle);
        end
        tx_reset = 1'b1;
        #1;
        step();
        tx_reset = 1'b0;
        vectors++;
        if (busy !== 1'b0 || tf_push !== 1'b0) begin
            miscompares++;
            $display("FAIL held_release: busy=%b push=%b, required 0 0", busy, tf_push);
        end
    endtask

    task automatic test_tx_reset();
        int n0;
        drain = 1'b1;
        grant_log.delete();
        for (int k = 0; k < 8; k++) begin
            rq[0].push_back({(k == 7), 8'(8'h50 + k)});
            exp_q.push_back(8'(8'h50 + k));
        end
        drive_inputs();
        n0 = n_push;
        repeat (4) step();
        tx_reset = 1'b1;
        #1;
        vectors++;
        if (req_ready !== 4'b0) begin
            miscompares++;
            $display("FAIL txr_ready: got %b required 0000", req_ready);
        end
        step();
        tx_reset = 1'b0;
        vectors++;
        if (tf_push !== 1'b0 || busy !== 1'b0 || n_push - n0 != 3) begin
            miscompares++;
            $display("FAIL txr_stop: push=%b busy=%b bytes_out=%0d, required 0 0 3", tf_push, busy, n_push - n0);
        end
        rq[0].delete();
        exp_q.delete();
        grant_log.delete();
        rq[0] = '{9'h0F0, 9'h0F1, 9'h1F2};
        rq[2] = '{9'h070, 9'h171};
        exp_q = '{8'hF0, 8'hF1, 8'hF2, 8'h70, 8'h71};
        drive_inputs();
        wait_drain(60, "txr_restart");
        vectors++;
        if (grant_log.size() != 2 || grant_log[0] != 0 || grant_log[1] != 2) begin
            miscompares++;
            $display("FAIL txr_rr_ptr: got %0d grants first=%0d, required 0 then 2",
                     grant_log.size(), grant_log.size() > 0 ? grant_log[0] : -1);
        end
    endtask

    task automatic test_fifo_full();
        int  n;
        bit  seen15;
        n = 0;
        drain = 1'b1;
        while (fifo_cnt > 0 && n < 40) begin step(); n++; end
        drain    = 1'b0;
        overrun  = 1'b0;
        fifo_cnt = 5;
        for (int k = 0; k < 14; k++) begin
            rq[2].push_back({(k == 13), 8'(8'h80 + k)});
            exp_q.push_back(8'(8'h80 + k));
        end
        drive_inputs();
        n = 0;
        seen15 = 1'b0;
        while (fifo_cnt < 16 && n < 80) begin
            if (fifo_cnt == 15 && tf_push) begin
                seen15 = 1'b1;
                vectors++;
                if (req_ready !== 4'b0) begin
                    miscompares++;
                    $display("FAIL full_pending: ready=%b with count 15 and push pending, required 0000", req_ready);
                end
            end
            step();
            n++;
        end
        vectors++;
        if (n >= 80 || !seen15) begin
            miscompares++;
            $display("FAIL full_fill: cycles=%0d seen15=%0d, required fill with count 15 plus pending push", n, seen15);
        end
        repeat (3) begin
            vectors++;
            if (req_ready !== 4'b0 || tf_push !== 1'b0) begin
                miscompares++;
                $display("FAIL full_stall: ready=%b push=%b, required 0000 0", req_ready, tf_push);
            end
            step();
        end
        vectors++;
        if (rq[2].size() != 3) begin
            miscompares++;
            $display("FAIL full_accepted: remaining=%0d required 3", rq[2].size());
        end
        drain = 1'b1;
        wait_drain(120, "full_drain");
        vectors++;
        if (overrun) begin
            miscompares++;
            $display("FAIL tf_overrun: got 1 required 0");
        end
    endtask

    task automatic test_idle();
        int n;
        n = 0;
        drain = 1'b1;
        while (fifo_cnt > 0 && n < 40) begin step(); n++; end
        repeat (2) step();
        vectors++;
        if (tx_idle !== 1'b1) begin
            miscompares++;
            $display("FAIL idle_quiet: got %b required 1", tx_idle);
        end
        tstate = 3'd3;
        #1;
        step();
        vectors++;
        if (tx_idle !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_shifting: got %b required 0", tx_idle);
        end
        tstate = 3'd0;
        #1;
        vectors++;
        if (tx_idle !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_early: got %b required 0", tx_idle);
        end
        step();
        vectors++;
        if (tx_idle !== 1'b1) begin
            miscompares++;
            $display("FAIL idle_rise: got %b required 1", tx_idle);
        end
        drain = 1'b0;
        fifo_cnt = 2;
        drive_inputs();
        step();
        vectors++;
        if (tx_idle !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_fifo_nonempty: got %b required 0", tx_idle);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        req_valid   = '0;
        req_data    = '0;
        req_last    = '0;
        tf_count    = '0;
        tstate      = 3'd0;
        tx_reset    = 1'b0;
        drain       = 1'b1;
        overrun     = 1'b0;
        busy_prev   = 1'b0;
        fifo_cnt    = 0;
        cyc         = 0;
        n_push      = 0;
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_two_msgs();
        test_reset_mid_burst();
        test_burst_rotation();
        test_tx_reset();
        test_fifo_full();
        test_idle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
